// File: rtl/fifo_ram_ctrl.sv
// Controller that turns an 8-word single-port tri-state RAM into an 8-deep FIFO.
// One write and one read requester share the RAM; every access is one cycle followed by IDLE.
module fifo_ram_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_req,
  input  logic [N-1:0] wr_data,
  output logic         wr_ack,
  input  logic         rd_req,
  output logic         rd_ack,
  output logic [N-1:0] rd_data,
  output logic         rd_valid,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [3:0]   count,
  inout  wire  [N-1:0] ram_io,
  output logic [2:0]   ram_addr,
  output logic         ram_cs,
  output logic         ram_rw
);

  localparam int DEPTH = 8;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t       state_q, state_d;
  logic [2:0]   wptr_q, wptr_d;
  logic [2:0]   rptr_q, rptr_d;
  logic [3:0]   count_q, count_d;
  logic         last_wr_q, last_wr_d;
  logic         rd_valid_q, rd_valid_d;
  logic [N-1:0] rd_data_q, rd_data_d;
  logic [N-1:0] wbuf_q, wbuf_d;
  logic         ew, er;

  assign full  = (count_q == 4'(DEPTH));
  assign empty = (count_q == 4'd0);
  assign count = count_q;

  assign ew = wr_req & ~full;
  assign er = rd_req & ~empty;

  // Bus-side outputs come only from registered state so they never glitch.
  assign ram_cs   = (state_q != IDLE);
  assign ram_rw   = (state_q == WR);
  assign wr_ack   = (state_q == WR);
  assign rd_ack   = (state_q == RD);
  assign ram_addr = (state_q == WR) ? wptr_q :
                    (state_q == RD) ? rptr_q : 3'd0;
  assign ram_io   = (state_q == WR) ? wbuf_q : {N{1'bz}};

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    last_wr_d  = last_wr_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wbuf_d     = wbuf_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          wptr_d  = 3'd0;
          rptr_d  = 3'd0;
          count_d = 4'd0;
        end else if (ew && (!er || !last_wr_q)) begin
          // On a tie the side not served last wins.
          state_d = WR;
          wbuf_d  = wr_data;
        end else if (er) begin
          state_d = RD;
        end
      end
      WR: begin
        wptr_d    = wptr_q + 3'd1;
        count_d   = count_q + 4'd1;
        last_wr_d = 1'b1;
        state_d   = IDLE;
      end
      RD: begin
        rd_data_d  = ram_io;
        rptr_d     = rptr_q + 3'd1;
        count_d    = count_q - 4'd1;
        last_wr_d  = 1'b0;
        rd_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= 3'd0;
      rptr_q     <= 3'd0;
      count_q    <= 4'd0;
      last_wr_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      last_wr_q  <= last_wr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Write buffer is pure data and only read back in WR, so it needs no reset.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: behavioural tri-state RAM, pointer/count model and a data scoreboard.
module tb_fifo_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req, rd_req, flush;
  logic [7:0] wr_data;
  logic       wr_ack, rd_ack, rd_valid, full, empty, ram_cs, ram_rw;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic [2:0] ram_addr;
  wire  [7:0] ram_io;

  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  logic [2:0] wptr_m, rptr_m;
  int         count_m;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  fifo_ram_ctrl #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .full(full), .empty(empty), .count(count),
    .ram_io(ram_io), .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_rw(ram_rw)
  );

  assign ram_io = (ram_cs && !ram_rw) ? mem[ram_addr] : 8'hzz;
  always @(posedge clk) if (ram_cs && ram_rw) mem[ram_addr] <= ram_io;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) check_val("rd_q_size", exp_q.size(), 1);
      else check_val("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic wait_wr(input logic [7:0] d, input int budget, output int lat);
    bit got = 0;
    lat = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (wr_ack) begin
        got = 1;
        lat = i;
        check_val("wr_addr", ram_addr, wptr_m);
        check_val("wr_cs_rw", {ram_cs, ram_rw}, 2'b11);
        check_val("wr_bus", ram_io, d);
        exp_q.push_back(d);
        wptr_m++;
        count_m++;
      end
    end
    check_val("wr_grant", got, 1);
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic wait_rd(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (rd_ack) begin
        got = 1;
        check_val("rd_addr", ram_addr, rptr_m);
        check_val("rd_cs_rw", {ram_cs, ram_rw}, 2'b10);
        rptr_m++;
        count_m--;
      end
    end
    check_val("rd_grant", got, 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d);
    int lat;
    wr_data = d;
    wr_req  = 1'b1;
    wait_wr(d, 20, lat);
    check_val("wr_count", count, count_m);
  endtask

  task automatic do_read();
    rd_req = 1'b1;
    wait_rd(20);
    check_val("rd_valid", rd_valid, 1);
    check_val("rd_count", count, count_m);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    wptr_m = 0; rptr_m = 0; count_m = 0;
    check_val("flush_count", count, 0);
    check_val("flush_empty", empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, acks, cs_seen, grants, guard, bad;
    logic [7:0] order, nxt;
    bit   got;

    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; wr_data = 8'h00;
    wptr_m = 0; rptr_m = 0; count_m = 0;
    repeat (2) @(posedge clk); #1;
    check_val("rst_count", count, 0);
    check_val("rst_flags", {empty, full}, 2'b10);
    check_val("rst_outs", {wr_ack, rd_ack, rd_valid, ram_cs, ram_rw}, 5'b0);
    check_val("rst_addr_data", {ram_addr, rd_data}, 11'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("idle_cs", ram_cs, 0);
    check_val("idle_empty", empty, 1);

    // Reset arriving in the middle of a write abandons it.
    wr_data = 8'h77; wr_req = 1'b1; got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (wr_ack) got = 1;
    end
    check_val("midwr_ack", got, 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("midwr_cs", ram_cs, 0);
    check_val("midwr_ack_low", wr_ack, 0);
    check_val("midwr_count", count, 0);
    wr_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("midwr_empty", empty, 1);

    // Single write then read.
    wr_data = 8'hA5; wr_req = 1'b1;
    wait_wr(8'hA5, 20, lat);
    check_val("wr_latency", lat, 1);
    check_val("a5_count", count, 1);
    do_read();
    @(negedge clk);
    check_val("a5_final_count", count, 0);

    // Fill to full, hold a ninth write, free a slot, then see it land at address 0.
    do_flush();
    for (int k = 1; k <= 8; k++) do_write(8'(k));
    check_val("full_flag", full, 1);
    check_val("full_count", count, 8);
    wr_data = 8'h09; wr_req = 1'b1; acks = 0; cs_seen = 0;
    repeat (10) begin
      @(negedge clk);
      acks += int'(wr_ack);
      cs_seen |= int'(ram_cs);
    end
    check_val("full_hold_ack", acks, 0);
    check_val("full_hold_cs", cs_seen, 0);
    rd_req = 1'b1;
    wait_rd(20);
    check_val("wrap_wptr", wptr_m, 0);
    wait_wr(8'h09, 20, lat);
    check_val("after9_count", count, 8);

    // Drain, then a read on an empty FIFO waits for data.
    repeat (8) do_read();
    check_val("drained_empty", empty, 1);
    rd_req = 1'b1; acks = 0; cs_seen = 0;
    repeat (10) begin
      @(negedge clk);
      acks += int'(rd_ack);
      cs_seen |= int'(ram_cs);
    end
    check_val("empty_hold_ack", acks, 0);
    check_val("empty_hold_cs", cs_seen, 0);
    wr_data = 8'h3C; wr_req = 1'b1;
    wait_wr(8'h3C, 20, lat);
    wait_rd(20);
    @(negedge clk);
    check_val("3c_count", count, 0);

    // Bring occupancy to 4 with a read served last, then contend continuously.
    for (int k = 0; k < 5; k++) do_write(8'h40 + 8'(k));
    do_read();
    check_val("pre_alt_count", count, 4);
    nxt = 8'h50; wr_data = nxt; wr_req = 1'b1; rd_req = 1'b1;
    grants = 0; guard = 0; order = 8'h00; bad = 0;
    while (grants < 8 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (count < 4 || count > 5) bad = 1;
      if (wr_ack) begin
        check_val("alt_wr_addr", ram_addr, wptr_m);
        check_val("alt_wr_bus", ram_io, nxt);
        exp_q.push_back(nxt);
        wptr_m++; count_m++;
        order = {order[6:0], 1'b1};
        grants++;
        nxt++;
        @(posedge clk); #1;
        wr_data = nxt;
      end else if (rd_ack) begin
        check_val("alt_rd_addr", ram_addr, rptr_m);
        rptr_m++; count_m--;
        order = {order[6:0], 1'b0};
        grants++;
        if (grants == 8) begin
          @(posedge clk); #1;
        end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check_val("alt_order", order, 8'hAA);
    check_val("alt_count_range", bad, 0);
    @(negedge clk);
    check_val("alt_end_count", count, 4);

    // Flush in IDLE, then flush raised during a read.
    do_write(8'h60);
    check_val("pre_flush_count", count, 5);
    do_flush();
    do_write(8'h61);
    do_write(8'h62);
    rd_req = 1'b1; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_ack) got = 1;
    end
    check_val("flushrd_grant", got, 1);
    check_val("flushrd_addr", ram_addr, rptr_m);
    flush = 1'b1;
    rptr_m++; count_m--;
    @(posedge clk); #1;
    rd_req = 1'b0;
    check_val("flushrd_valid", rd_valid, 1);
    check_val("flushrd_count_mid", count, 1);
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    wptr_m = 0; rptr_m = 0; count_m = 0;
    check_val("flushrd_count", count, 0);
    check_val("flushrd_empty", empty, 1);

    repeat (3) @(posedge clk);
    #1;
    check_val("final_idle_cs", ram_cs, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ram_ctrl.md
Name: fifo_ram_ctrl

Overview:
- Sequencing controller that turns the 8-word single-port tri-state RAM into an 8-deep FIFO.
- Arbitrates between one write requester and one read requester, and generates ram_addr, ram_cs and ram_rw.
- Owns the controller side of the shared bidirectional data bus and tracks pointers, occupancy, full and empty.
- Sits between FIFO producer/consumer logic and the RAM instance.

Parameters:
- N, 8, data width; must match the RAM data width.
- DEPTH, 8, fixed by the 3-bit RAM address; not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_req  input  1  write request; held high until wr_ack, with wr_data stable.
- wr_data  input  N  write data.
- wr_ack  output  1  write grant; high during the write access cycle.
- rd_req  input  1  read request; held high until rd_ack.
- rd_ack  output  1  read grant; high during the read access cycle.
- rd_data  output  N  read data, registered.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- flush  input  1  synchronous clear of FIFO state.
- full  output  1  count==8.
- empty  output  1  count==0.
- count  output  4  occupancy, 0..8.
- ram_io  inout  N  RAM data bus.
- ram_addr  output  3  RAM address.
- ram_cs  output  1  RAM chip select.
- ram_rw  output  1  1 = write, 0 = read (RAM drives the bus).

Behaviour:
- Reset (rst_n low, async): state IDLE; wptr=rptr=0; count=0; empty=1; full=0; wr_ack=rd_ack=rd_valid=0; rd_data=0; ram_cs=0; ram_rw=0; ram_addr=0; ram_io released (Z). Same values apply if reset hits mid-access; the access in flight is abandoned and no pointer moves.
- FSM states: IDLE, WR, RD. Every access is exactly one cycle, and every access returns to IDLE, so peak throughput is one operation per 2 cycles.
- IDLE decision, evaluated in priority order:
  - flush=1: wptr=rptr=count=0, remain IDLE, no grant.
  - ew = wr_req & ~full; er = rd_req & ~empty.
  - Only ew: go to WR and capture wr_data into wbuf.
  - Only er: go to RD.
  - Both: grant the side not served last (last_wr flag). After reset last_wr=0, so write wins the first tie.
  - Neither: stay in IDLE.
- WR cycle: ram_cs=1, ram_rw=1, ram_addr=wptr, ram_io driven with wbuf, wr_ack=1. At the end of the cycle: wptr+1 (wrapping 7->0), count+1, last_wr=1, go to IDLE.
- RD cycle: ram_cs=1, ram_rw=0, ram_addr=rptr, ram_io Z from the controller, rd_ack=1. At the end of the cycle: rd_data<=ram_io, rptr+1 (wrap), count-1, last_wr=0, go to IDLE. rd_valid=1 during the following IDLE cycle only.
- IDLE cycle outputs: ram_cs=0, ram_rw=0, ram_addr=0, bus Z. Both sides are released on every IDLE cycle, which guarantees one turnaround cycle between RAM drive and controller drive.
- The controller drives ram_io only in WR.
- ram_cs, ram_rw, ram_addr, wr_ack and rd_ack are decoded only from registered state, pointers and wbuf, so they are glitch-free.
- Full/empty gating: wr_req while full, or rd_req while empty, is held off with no ack and no pointer or count change until space or data exists.
- flush in WR/RD: the current access completes; flush takes effect in the next IDLE if still high, and has priority over requests there.
- count is never below 0 or above 8; full and empty are combinational from count.

Test Plan:
- Reset then idle: count=0, empty=1, full=0, ram_cs=0, ram_io=Z; assert rst_n=0 mid-WR -> ram_cs drops immediately, count stays 0.
- Write 0xA5 then read it: wr_ack on cycle 2; ram_addr=0, ram_rw=1, ram_io=0xA5 in WR; read gives rd_ack, ram_addr=0, ram_rw=0, then rd_valid with rd_data=0xA5; count ends at 0.
- Write 0x01..0x08: full=1, count=8. A 9th write (0x09) is held with no wr_ack for 10 cycles. Read one (0x01) -> the 9th write is granted at ram_addr=0 (wrap).
- Read while empty: rd_req held 10 cycles -> no rd_ack, no RAM access. Then a write of 0x3C -> that write, then the read, are granted; rd_data=0x3C.
- Continuous wr_req and rd_req with count=4 -> grants alternate W,R,W,R starting with W; count stays 4/5; read data order is preserved across the 7->0 pointer wrap.
- flush with count=5 in IDLE -> count=0, empty=1. flush asserted during RD -> the read completes with rd_valid, then count clears.
